// File: rtl/write_pixels_pkg.sv
// Shared types and constants for the TM1640-style serial display writer.
package write_pixels_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT_LO,
      BIT_HI,
      STOP_LO,
      STOP_HI,
      GAP
   } state_t;

   // A frame is either a lone command byte, the fixed-address data command, or address+pixel
   typedef enum logic [1:0] {
      FRAME_CMD,
      FRAME_DATACMD,
      FRAME_ADDR
   } frame_t;

   localparam logic [7:0] CMD_FIXED_ADDR = 8'h44;
   localparam logic [7:0] POS_CMD_ONLY   = 8'hFF;
   localparam logic [7:0] ADDR_BASE      = 8'hC0;

   function automatic logic [7:0] frameByte(frame_t kind, logic byteSel,
                                            logic [7:0] pos, logic [7:0] value);
      logic [7:0] result;
      case (kind)
         FRAME_DATACMD: result = CMD_FIXED_ADDR;
         FRAME_ADDR:    result = byteSel ? value : pos;
         default:       result = value;
      endcase
      return result;
   endfunction

   function automatic logic frameLastByte(frame_t kind, logic byteSel);
      return (kind != FRAME_ADDR) || byteSel;
   endfunction

endpackage

// File: rtl/write_pixels_if.sv
// Request/serial-pin bundle between the display sequencer and the writer.
interface write_pixels_if;
   logic       valid;
   logic [7:0] pos;
   logic [7:0] value;
   logic       o_sclk;
   logic       o_din;
   logic       busy;

   modport master (output valid, pos, value, input o_sclk, o_din, busy);
   modport slave  (input valid, pos, value, output o_sclk, o_din, busy);
endinterface

// File: rtl/write_pixels.sv
// Serial display writer: one (pos, value) request becomes one or two TM1640-style frames.
// Define WRITE_PIXELS_DATACMD_EN to prefix every pixel write with the 8'h44 data-command frame.
module write_pixels
   import write_pixels_pkg::*;
#(
   parameter int CLK_DIV = 12
) (
   input logic           CLK,
   input logic           rst_n,
   write_pixels_if.slave bus
);

   localparam int              PW         = $clog2(CLK_DIV) + 1;
   localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);

   state_t        state_q, state_d;
   frame_t        kind_q, kind_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [2:0]    bit_q, bit_d;
   logic          byte_q, byte_d;
   logic [7:0]    pos_q, pos_d;
   logic [7:0]    value_q, value_d;
   logic          sclk_q, sclk_d;
   logic          din_q, din_d;
   logic          busy_q, busy_d;
   logic          armed_q;
   logic          phaseDone;
   logic [7:0]    curByte;

   // armed_q keeps a request that arrives on the reset-release edge from being taken
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kind_q  <= FRAME_CMD;
         phase_q <= '0;
         bit_q   <= '0;
         byte_q  <= 1'b0;
         pos_q   <= '0;
         value_q <= '0;
         sclk_q  <= 1'b1;
         din_q   <= 1'b1;
         busy_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         pos_q   <= pos_d;
         value_q <= value_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      pos_d     = pos_q;
      value_d   = value_q;
      phaseDone = (phase_q == PHASE_LAST);

      if (state_q != IDLE) begin
         phase_d = phase_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.valid && armed_q) begin
               pos_d   = bus.pos;
               value_d = bus.value;
               bit_d   = '0;
               byte_d  = 1'b0;
               state_d = START;
`ifdef WRITE_PIXELS_DATACMD_EN
               kind_d  = (bus.pos == POS_CMD_ONLY) ? FRAME_CMD : FRAME_DATACMD;
`else
               kind_d  = (bus.pos == POS_CMD_ONLY) ? FRAME_CMD : FRAME_ADDR;
`endif
            end
         end
         START:   if (phaseDone) state_d = BIT_LO;
         BIT_LO:  if (phaseDone) state_d = BIT_HI;
         BIT_HI: begin
            if (phaseDone) begin
               bit_d   = bit_q + 3'd1;
               state_d = BIT_LO;
               if (bit_q == 3'd7) begin
                  if (frameLastByte(kind_q, byte_q)) begin
                     state_d = STOP_LO;
                  end else begin
                     byte_d = 1'b1;
                  end
               end
            end
         end
         STOP_LO: if (phaseDone) state_d = STOP_HI;
         STOP_HI: if (phaseDone) state_d = GAP;
         GAP: begin
            if (phaseDone) begin
               if (kind_q == FRAME_DATACMD) begin
                  kind_d  = FRAME_ADDR;
                  byte_d  = 1'b0;
                  bit_d   = '0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Every phase ends on phaseDone, so that is also where the timer restarts
      if (phaseDone) begin
         phase_d = '0;
      end

      curByte = frameByte(kind_d, byte_d, pos_d, value_d);
      sclk_d  = 1'b1;
      din_d   = 1'b1;
      case (state_d)
         START:   begin sclk_d = 1'b1; din_d = 1'b0;           end
         BIT_LO:  begin sclk_d = 1'b0; din_d = curByte[bit_d]; end
         BIT_HI:  begin sclk_d = 1'b1; din_d = curByte[bit_d]; end
         STOP_LO: begin sclk_d = 1'b0; din_d = 1'b0;           end
         STOP_HI: begin sclk_d = 1'b1; din_d = 1'b0;           end
         default: begin sclk_d = 1'b1; din_d = 1'b1;           end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.o_sclk = sclk_q;
   assign bus.o_din  = din_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_write_pixels.sv
// Randomized self-checking bench for write_pixels: a queue-based waveform model is compared
// every cycle, and a pin-level frame decoder pins directed cases to literal bytes and lengths.
module tb_write_pixels;
   import write_pixels_pkg::*;

   localparam int D = 2;

   logic CLK   = 1'b0;
   logic rst_n = 1'b0;
   always #5 CLK = ~CLK;

   write_pixels_if bus ();

   write_pixels #(.CLK_DIV(D)) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Expected {busy, sclk, din} for each upcoming cycle of the current request
   logic [2:0] expQ[$];
   bit         modelArmed  = 1'b0;
   bit         lastPopped  = 1'b0;

   logic [7:0] decBytes[$];
   int         decFrames   = 0;
   int         nBits       = 0;
   logic [7:0] shReg       = '0;
   bit         inFrame     = 1'b0;
   logic       prevSclk    = 1'b1;
   logic       prevDin     = 1'b1;
   int         busyRun     = 0;
   int         lastBusyLen = 0;

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, actual, expected);
      end
   endtask

   task automatic pushPhase(logic s, logic d);
      repeat (D) expQ.push_back({1'b1, s, d});
   endtask

   task automatic pushFrame(logic [7:0] b0, logic [7:0] b1, int nBytes);
      logic [7:0] b;
      pushPhase(1'b1, 1'b0);
      for (int k = 0; k < nBytes; k++) begin
         b = (k == 0) ? b0 : b1;
         for (int i = 0; i < 8; i++) begin
            pushPhase(1'b0, b[i]);
            pushPhase(1'b1, b[i]);
         end
      end
      pushPhase(1'b0, 1'b0);
      pushPhase(1'b1, 1'b0);
      pushPhase(1'b1, 1'b1);
   endtask

   task automatic modelAccept(logic [7:0] p, logic [7:0] v);
      if (p == 8'hFF) begin
         pushFrame(v, 8'h00, 1);
      end else begin
`ifdef WRITE_PIXELS_DATACMD_EN
         pushFrame(8'h44, 8'h00, 1);
`endif
         pushFrame(p, v, 2);
      end
   endtask

   // A request is taken only if the writer was idle in the cycle before the edge
   always @(posedge CLK) begin
      if (rst_n && modelArmed && bus.valid && !lastPopped && expQ.size() == 0) begin
         modelAccept(bus.pos, bus.value);
      end
      modelArmed = rst_n;
   end

   always @(negedge CLK) begin
      logic [2:0] e;
      logic       s, d;
      if (!rst_n) begin
         expQ.delete();
         e          = 3'b011;
         lastPopped = 1'b0;
      end else if (expQ.size() > 0) begin
         e          = expQ.pop_front();
         lastPopped = 1'b1;
      end else begin
         e          = 3'b011;
         lastPopped = 1'b0;
      end
      checkOutput("busy", bus.busy, e[2]);
      checkOutput("sclk", bus.o_sclk, e[1]);
      checkOutput("din", bus.o_din, e[0]);

      s = bus.o_sclk;
      d = bus.o_din;
      if (!rst_n) begin
         inFrame  = 1'b0;
         nBits    = 0;
         prevSclk = 1'b1;
         prevDin  = 1'b1;
         busyRun  = 0;
      end else begin
         if (prevSclk && s) begin
            if (prevDin && !d) begin
               inFrame = 1'b1;
               nBits   = 0;
            end else if (!prevDin && d && inFrame) begin
               inFrame = 1'b0;
               decFrames++;
            end
         end else if (!prevSclk && s && inFrame) begin
            shReg = {d, shReg[7:1]};
            nBits++;
            if (nBits % 8 == 0) decBytes.push_back(shReg);
         end
         prevSclk = s;
         prevDin  = d;
         if (bus.busy) begin
            busyRun++;
         end else if (busyRun > 0) begin
            lastBusyLen = busyRun;
            busyRun     = 0;
         end
      end
   end

   task automatic applyStimulus(logic [7:0] p, logic [7:0] v);
      @(negedge CLK);
      bus.valid = 1'b1;
      bus.pos   = p;
      bus.value = v;
      @(negedge CLK);
      bus.valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((bus.busy || expQ.size() > 0) && n < 5000);
      checkOutput("idle_timeout", (n < 5000), 1);
      @(negedge CLK);
   endtask

   task automatic clearLog();
      decBytes.delete();
      decFrames = 0;
   endtask

   task automatic checkPixelResult(string tag);
`ifdef WRITE_PIXELS_DATACMD_EN
      checkOutput({tag, "_frames"}, decFrames, 2);
      checkOutput({tag, "_nbytes"}, decBytes.size(), 3);
      if (decBytes.size() == 3) begin
         checkOutput({tag, "_b0"}, decBytes[0], 8'h44);
         checkOutput({tag, "_b1"}, decBytes[1], 8'hC3);
         checkOutput({tag, "_b2"}, decBytes[2], 8'h7F);
      end
      checkOutput({tag, "_busylen"}, lastBusyLen, 56 * D);
`else
      checkOutput({tag, "_frames"}, decFrames, 1);
      checkOutput({tag, "_nbytes"}, decBytes.size(), 2);
      if (decBytes.size() == 2) begin
         checkOutput({tag, "_b0"}, decBytes[0], 8'hC3);
         checkOutput({tag, "_b1"}, decBytes[1], 8'h7F);
      end
      checkOutput({tag, "_busylen"}, lastBusyLen, 36 * D);
`endif
   endtask

   task automatic checkCmdResult(string tag, logic [7:0] v);
      checkOutput({tag, "_frames"}, decFrames, 1);
      checkOutput({tag, "_nbytes"}, decBytes.size(), 1);
      if (decBytes.size() == 1) checkOutput({tag, "_b0"}, decBytes[0], v);
      checkOutput({tag, "_busylen"}, lastBusyLen, 20 * D);
   endtask

   initial begin
      logic [7:0] rp, rv;
      bus.valid = 1'b0;
      bus.pos   = 8'h00;
      bus.value = 8'h00;

      // Reset levels, then a request on the release cycle must be dropped
      repeat (3) @(negedge CLK);
      checkOutput("rst_sclk", bus.o_sclk, 1);
      checkOutput("rst_din", bus.o_din, 1);
      checkOutput("rst_busy", bus.busy, 0);
      bus.valid = 1'b1;
      bus.pos   = 8'hFF;
      bus.value = 8'h12;
      #1 rst_n = 1'b1;
      @(negedge CLK);
      bus.valid = 1'b0;
      repeat (100) @(negedge CLK);
      checkOutput("idle_busy", bus.busy, 0);
      checkOutput("idle_sclk", bus.o_sclk, 1);
      checkOutput("idle_frames", decFrames, 0);

      clearLog();
      applyStimulus(8'hFF, 8'h89);
      waitIdle();
      checkCmdResult("cmd89", 8'h89);

      clearLog();
      applyStimulus(8'hC3, 8'h7F);
      waitIdle();
      checkPixelResult("pix");

      // A second request during the frame must not disturb it
      clearLog();
      applyStimulus(8'hC3, 8'h7F);
      repeat (30) @(negedge CLK);
      applyStimulus(8'hFF, 8'h00);
      waitIdle();
      checkPixelResult("midvalid");

      // valid held high: the next request lands in the cycle busy drops
      clearLog();
      @(negedge CLK);
      bus.valid = 1'b1;
      bus.pos   = 8'hFF;
      bus.value = 8'hA5;
      repeat (20 * D + 3) @(negedge CLK);
      bus.valid = 1'b0;
      waitIdle();
      checkOutput("b2b_frames", decFrames, 2);
      checkOutput("b2b_nbytes", decBytes.size(), 2);
      checkOutput("b2b_busylen", lastBusyLen, 20 * D);

      for (int r = 0; r < 12; r++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         rp = ($urandom_range(0, 2) == 0) ? 8'hFF : ADDR_BASE + 8'($urandom_range(0, 15));
         rv = 8'($urandom);
         applyStimulus(rp, rv);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 30)) @(negedge CLK);
            applyStimulus(8'($urandom), 8'($urandom));
         end
         waitIdle();
      end

      // Reset in the first BIT_HI of a 0x89 frame (bit0 = 1)
      clearLog();
      applyStimulus(8'hFF, 8'h89);
      repeat (4) @(negedge CLK);
      checkOutput("bithi_sclk", bus.o_sclk, 1);
      checkOutput("bithi_din", bus.o_din, 1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("abort_sclk", bus.o_sclk, 1);
      checkOutput("abort_din", bus.o_din, 1);
      checkOutput("abort_busy", bus.busy, 0);
      repeat (3) @(negedge CLK);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge CLK);
      clearLog();
      applyStimulus(8'hFF, 8'h5A);
      waitIdle();
      checkCmdResult("after_rst", 8'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
